// File: rtl/thumb_fetch_pkg.sv
// thumb_fetch_pkg: constants and types shared by the Thumb fetch unit.
// Holds the NOP encoding, FSM state encodings and the default boot address.
package thumb_fetch_pkg;

  localparam logic [15:0] THUMB_NOP        = 16'h46C0;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    F_IDLE = 2'b00,
    F_WAIT = 2'b01,
    F_DROP = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/hw_fifo.sv
// hw_fifo: halfword queue that accepts one or two entries per cycle
// and releases at most one; flush empties it in a single cycle.
module hw_fifo
  import thumb_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push2,
  input  logic          push1,
  input  logic [15:0]   d0,
  input  logic [15:0]   d1,
  input  logic          pop,
  input  logic          flush,
  output logic [15:0]   head,
  output logic [CW-1:0] count
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q, free;
  logic          do_pop, do_push2, do_push1;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign free     = CW'(DEPTH) - cnt_q;
  assign do_pop   = pop && (cnt_q != '0);
  assign do_push2 = push2 && (free >= CW'(2));
  assign do_push1 = push1 && !push2 && (free >= CW'(1));
  assign head     = mem[rd_q];
  assign count    = cnt_q;

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (do_push2 || do_push1) mem[wr_q] <= d0;
      if (do_push2) mem[inc(wr_q)] <= d1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_pop) rd_q <= inc(rd_q);
      if (do_push2) wr_q <= inc(inc(wr_q));
      else if (do_push1) wr_q <= inc(wr_q);
      cnt_q <= cnt_q + CW'({do_push2, do_push1}) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/thumb_fetch.sv
// thumb_fetch: Thumb instruction fetch with a halfword queue, one word
// request in flight at a time, and execute-stage redirects.
module thumb_fetch
  import thumb_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int          QDEPTH       = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_stall,
  output logic [15:0] inst,
  output logic [31:0] if_pc,
  output logic        inst_valid
);

  localparam int CW = $clog2(QDEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_q, req_addr_q, out_pc_q;
  logic          skip_q;
  logic [CW-1:0] q_cnt;
  logic [15:0]   q_head, lo, hi, head_sel, fifo_d0;
  logic          room, done, acc, q_any;
  logic          take, bypass, push2, push1, pop;

  assign lo = imem_rdata[15:0];
  assign hi = imem_rdata[31:16];

  assign room      = q_cnt <= CW'(QDEPTH - 2);
  assign imem_req  = !rst && ((state_q != F_IDLE) || room);
  assign imem_addr = (state_q == F_IDLE) ? fetch_q : req_addr_q;
  assign done      = imem_req && imem_ack;
  assign acc       = done && (state_q != F_DROP) && !br_taken;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      F_IDLE: begin
        if (imem_req && !imem_ack)
          state_d = br_taken ? F_DROP : F_WAIT;
      end
      F_WAIT: begin
        if (imem_ack) state_d = F_IDLE;
        else if (br_taken) state_d = F_DROP;
      end
      F_DROP: begin
        if (imem_ack) state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= F_IDLE;
      fetch_q    <= RESET_VECTOR;
      req_addr_q <= RESET_VECTOR;
      skip_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == F_IDLE && state_d != F_IDLE)
        req_addr_q <= fetch_q;
      if (br_taken) begin
        fetch_q <= br_target & ~32'h3;
        skip_q  <= br_target[1];
      end else if (acc) begin
        fetch_q <= fetch_q + 32'd4;
        skip_q  <= 1'b0;
      end
    end
  end

  // An empty queue forwards the arriving word straight to the output.
  assign q_any    = q_cnt != '0;
  assign take     = !br_taken && !id_stall && (q_any || acc);
  assign bypass   = take && !q_any;
  assign pop      = take && q_any;
  assign head_sel = q_any ? q_head : (skip_q ? hi : lo);
  assign push2    = acc && !skip_q && !bypass;
  assign push1    = acc && (skip_q ? !bypass : bypass);
  assign fifo_d0  = (bypass || skip_q) ? hi : lo;

  hw_fifo #(.DEPTH(QDEPTH)) u_q (
    .clk   (clk),
    .rst   (rst),
    .push2 (push2),
    .push1 (push1),
    .d0    (fifo_d0),
    .d1    (hi),
    .pop   (pop),
    .flush (br_taken),
    .head  (q_head),
    .count (q_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst       <= THUMB_NOP;
      if_pc      <= '0;
      inst_valid <= 1'b0;
      out_pc_q   <= RESET_VECTOR;
    end else if (br_taken) begin
      inst       <= THUMB_NOP;
      inst_valid <= 1'b0;
      out_pc_q   <= br_target & ~32'h1;
    end else if (!id_stall) begin
      if (take) begin
        inst       <= head_sel;
        if_pc      <= out_pc_q + 32'd4;
        inst_valid <= 1'b1;
        out_pc_q   <= out_pc_q + 32'd2;
      end else begin
        inst       <= THUMB_NOP;
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_thumb_fetch.sv
// tb_thumb_fetch: directed scenarios with a memory model feeding an
// expected-halfword queue that is checked against the decode outputs.
module tb_thumb_fetch;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [15:0] NOP = 16'h46C0;

  typedef struct {
    logic [15:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        id_stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [15:0] inst;
  logic [31:0] if_pc;
  logic        inst_valid;

  exp_t        sb[$];
  logic [31:0] exp_fetch = RV;
  logic        skip_m = 1'b0;
  logic        pend = 1'b0;
  logic        taint = 1'b0;
  int          wait_n = 0;
  int          ack_delay = 0;
  int          nacc = 0;
  logic [15:0] e_inst = NOP;
  logic [31:0] e_pc = '0;
  logic        e_valid = 1'b0;
  int          nvec = 0;
  int          nbad = 0;

  thumb_fetch #(.RESET_VECTOR(RV), .QDEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .id_stall   (id_stall),
    .inst       (inst),
    .if_pc      (if_pc),
    .inst_valid (inst_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hwf(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'h3C5A;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hB401_2000;
    if (a == 32'h4) return 32'h4770_1C08;
    return {hwf(a + 32'd2), hwf(a)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory answers, scoreboard updates, outputs checked.
  task automatic step();
    logic        ack_now;
    logic [31:0] w;
    exp_t        e;
    ack_now = 1'b0;
    if (imem_req) begin
      if (!pend) begin
        pend   = 1'b1;
        wait_n = 0;
      end
      ack_now = (wait_n >= ack_delay);
      if (br_taken) taint = 1'b1;
    end
    w = mem_word(imem_addr);
    imem_ack   = ack_now;
    imem_rdata = ack_now ? w : $urandom;
    if (ack_now) begin
      nacc++;
      if (!taint) begin
        chk("fetch_addr", imem_addr, exp_fetch);
        if (!skip_m) begin
          e.inst = w[15:0];
          e.pc   = exp_fetch + 32'd4;
          sb.push_back(e);
        end
        e.inst = w[31:16];
        e.pc   = exp_fetch + 32'd6;
        sb.push_back(e);
        exp_fetch = exp_fetch + 32'd4;
        skip_m    = 1'b0;
      end
      pend  = 1'b0;
      taint = 1'b0;
    end else if (imem_req) begin
      wait_n++;
    end
    if (br_taken) begin
      sb.delete();
      exp_fetch = br_target & ~32'h3;
      skip_m    = br_target[1];
      e_inst    = NOP;
      e_valid   = 1'b0;
    end else if (!id_stall) begin
      if (sb.size() != 0) begin
        e       = sb.pop_front();
        e_inst  = e.inst;
        e_pc    = e.pc;
        e_valid = 1'b1;
      end else begin
        e_inst  = NOP;
        e_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("inst", {16'h0, inst}, {16'h0, e_inst});
    chk("inst_valid", {31'h0, inst_valid}, {31'h0, e_valid});
    if (e_valid) chk("if_pc", if_pc, e_pc);
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic do_reset(input int cyc);
    rst      = 1'b1;
    br_taken = 1'b0;
    id_stall = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RV);
    chk("rst_inst", {16'h0, inst}, {16'h0, NOP});
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    sb.delete();
    exp_fetch = RV;
    skip_m    = 1'b0;
    pend      = 1'b0;
    taint     = 1'b0;
    wait_n    = 0;
    e_inst    = NOP;
    e_valid   = 1'b0;
    e_pc      = '0;
    repeat (cyc) begin
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      @(posedge clk);
      #1;
      chk("rst_hold_valid", {31'h0, inst_valid}, 32'h0);
      chk("rst_hold_req", {31'h0, imem_req}, 32'h0);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    rst      = 1'b0;
    #1;
    chk("boot_req", {31'h0, imem_req}, 32'h1);
    chk("boot_addr", imem_addr, RV);
  endtask

  task automatic boot_seq();
    logic [15:0] si [4];
    logic [31:0] sp [4];
    si = '{16'h2000, 16'hB401, 16'h1C08, 16'h4770};
    sp = '{32'h4, 32'h6, 32'h8, 32'hA};
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_inst", {16'h0, inst}, {16'h0, si[i]});
      chk("seq_if_pc", if_pc, sp[i]);
    end
  endtask

  initial begin
    logic [31:0] old;
    logic [31:0] w;
    int          n0;
    @(negedge clk);
    do_reset(2);
    boot_seq();

    // short stall with a valid instruction on the outputs
    id_stall = 1'b1;
    repeat (3) step();
    id_stall = 1'b0;
    repeat (6) step();

    // redirect to 0x102 while a delayed request is outstanding
    ack_delay = 3;
    for (int i = 0; i < 20 && !(pend && wait_n > 0); i++) step();
    chk("pending_req", {31'h0, imem_req}, 32'h1);
    old       = exp_fetch;
    br_taken  = 1'b1;
    br_target = 32'h0000_0102;
    step();
    br_taken  = 1'b0;
    chk("drop_req", {31'h0, imem_req}, 32'h1);
    chk("drop_addr", imem_addr, old);
    for (int i = 0; i < 30 && !inst_valid; i++) step();
    w = mem_word(32'h100);
    chk("redir_inst", {16'h0, inst}, {16'h0, w[31:16]});
    chk("redir_if_pc", if_pc, 32'h106);
    ack_delay = 0;
    repeat (6) step();

    // redirect coincident with ACK while decode stalls
    for (int i = 0; i < 10 && !imem_req; i++) step();
    id_stall  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h0000_0300;
    step();
    br_taken  = 1'b0;
    chk("brack_valid", {31'h0, inst_valid}, 32'h0);
    step();
    id_stall = 1'b0;
    repeat (8) step();

    // long stall from an empty queue: exactly two words fit
    id_stall  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h0000_0200;
    step();
    br_taken  = 1'b0;
    n0 = nacc;
    repeat (6) step();
    chk("stall_reqs", nacc - n0, 32'd2);
    id_stall = 1'b0;
    repeat (8) step();

    // address wrap at the top of memory
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFC;
    step();
    br_taken  = 1'b0;
    step();
    chk("wrap_valid", {31'h0, inst_valid}, 32'h1);
    chk("wrap_if_pc", if_pc, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);
    repeat (6) step();

    // reset while a request waits for its ACK
    ack_delay = 3;
    for (int i = 0; i < 20 && !(pend && wait_n > 0); i++) step();
    chk("wait_req", {31'h0, imem_req}, 32'h1);
    do_reset(2);
    ack_delay = 0;
    boot_seq();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
